// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser
//
// Controls one vending transaction: it drives a product-slot motor until the
// drop sensor confirms the item, then ejects change one coin at a time. Each
// coin must be confirmed by the exit sensor before the next one is ejected.
// If a sensor does not respond within TIMEOUT cycles, the block stops in a
// sticky FAULT state and stays there until `clear` is asserted.
//
// Optional feature (compile-time macro VEND_DISPENSE_COUNT_EN):
//   defined   : vend_count counts successful jobs and wraps from 255 to 0.
//   undefined : vend_count is tied to 0 and no counter logic is built.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   load         in   one-cycle job strobe (pro/change valid with it)
//   pro[1:0]     in   product code: 0 none, 1..3 slot 1..3
//   change[2:0]  in   coins to return, 0..7
//   prod_sense   in   product-drop sensor
//   coin_sense   in   coin-exit sensor
//   clear        in   synchronous fault clear, active-high
//   busy         out  high whenever the FSM is not idle
//   prod_motor   out  one-hot slot motor drive while vending
//   coin_pulse   out  one-cycle eject command to the hopper
//   done         out  one-cycle pulse on successful completion
//   fault        out  high while in FAULT
//   vend_count   out  successful-job counter (see macro above)
//   dbg_state_o  out  current FSM state (debug)
//   dbg_remain_o out  coins still owed for the current/last job (debug)
//
// Handshake: load is a fire-and-forget strobe with no ready signal. It is
// accepted only in a cycle where busy=0; while busy=1 it is ignored and the
// latched job is left untouched.
// -----------------------------------------------------------------------------
module vend_dispenser #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] pro,
  input  logic [2:0] change,
  input  logic       prod_sense,
  input  logic       coin_sense,
  input  logic       clear,
  output logic       busy,
  output logic [2:0] prod_motor,
  output logic       coin_pulse,
  output logic       done,
  output logic       fault,
  output logic [7:0] vend_count,
  output logic [2:0] dbg_state_o,
  output logic [2:0] dbg_remain_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_VEND      = 3'd1;
  localparam logic [2:0] S_CHG_PULSE = 3'd2;
  localparam logic [2:0] S_CHG_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  // Last count value that may still wait; the waiting state therefore lasts
  // exactly TIMEOUT cycles when the sensor never answers.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [2:0] remain_q, remain_d;
  logic [7:0] tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    remain_d = remain_q;
    // Counter clears on every state change; only the waiting states advance it.
    tmo_d    = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          slot_d   = pro;
          remain_d = change;
          if (pro != 2'd0)         state_d = S_VEND;
          else if (change != 3'd0) state_d = S_CHG_PULSE;
          else                     state_d = S_DONE;
        end
      end
      S_VEND: begin
        if (prod_sense) begin
          state_d = (remain_q != 3'd0) ? S_CHG_PULSE : S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_CHG_PULSE: begin
        // coin_sense is deliberately not looked at in this cycle.
        state_d = S_CHG_WAIT;
      end
      S_CHG_WAIT: begin
        if (coin_sense) begin
          remain_d = remain_q - 3'd1;
          state_d  = (remain_q != 3'd1) ? S_CHG_PULSE : S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // remain_q keeps the unpaid coin count for inspection.
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clear) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      slot_q   <= 2'd0;
      remain_q <= 3'd0;
      tmo_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      remain_q <= remain_d;
      tmo_q    <= tmo_d;
    end
  end

  // All outputs decode directly from registered state, so an asynchronous
  // reset drives them to their idle values at once.
  always_comb begin
    prod_motor = 3'b000;
    if (state_q == S_VEND) begin
      case (slot_q)
        2'd1:    prod_motor = 3'b001;
        2'd2:    prod_motor = 3'b010;
        2'd3:    prod_motor = 3'b100;
        default: prod_motor = 3'b000;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign coin_pulse   = (state_q == S_CHG_PULSE);
  assign done         = (state_q == S_DONE);
  assign fault        = (state_q == S_FAULT);
  assign dbg_state_o  = state_q;
  assign dbg_remain_o = remain_q;

`ifdef VEND_DISPENSE_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else if (state_q == S_DONE) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign vend_count = count_q;
`else
  assign vend_count = 8'd0;
`endif

endmodule
